io_output_buffer: RTL and testbench

- Character output buffer between the subleq core's I/O write port and the `io_output` sink.
- Absorbs bursts of core writes into a FIFO, then drains them to the sink as single-cycle `out_write` pulses. Pulses are paced by a minimum spacing so a slower sink (UART-class) can be dropped in later.
- Reports fill level and a sticky overflow flag for debug and the testbench.

---
 rtl/io_output_buffer.sv | 99 +++++++++
 tb/tb_io_output_buffer.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/io_output_buffer.sv
// Character output buffer: absorbs core write bursts in a FIFO and drains them to the
// sink as single-cycle out_write pulses spaced at least PACE clocks apart.

`ifndef WORD_SIZE
`define WORD_SIZE 16
`endif

module io_output_buffer #(
  parameter int unsigned WIDTH = `WORD_SIZE,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned PACE  = 4
) (
  input  logic                       clk,
  input  logic                       areset,
  input  logic                       cpu_write,
  input  logic [WIDTH-1:0]           cpu_data,
  output logic                       cpu_ready,
  output logic                       out_write,
  output logic [WIDTH-1:0]           io_out,
  output logic [$clog2(DEPTH):0]     fifo_count,
  output logic                       overflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned PW = $clog2(PACE) + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [PW-1:0]    pace_q, pace_d;
  logic             out_write_q, out_write_d;
  logic [WIDTH-1:0] io_out_q, io_out_d;
  logic             overflow_q, overflow_d;
  logic             push, pop;

  assign cpu_ready = (count_q < CW'(DEPTH));
  // Both decisions use pre-edge state, so a fresh push into an empty FIFO is never popped
  // on the same edge and a same-edge pop never frees room for a write.
  assign push = cpu_write & cpu_ready;
  assign pop  = (count_q != '0) && (pace_q == '0);

  always_comb begin
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    count_d     = count_q + CW'(push) - CW'(pop);
    pace_d      = pace_q;
    out_write_d = 1'b0;
    io_out_d    = io_out_q;
    overflow_d  = overflow_q | (cpu_write & ~cpu_ready);

    if (push) begin
      wptr_d = wptr_q + AW'(1);
    end

    if (pop) begin
      rptr_d      = rptr_q + AW'(1);
      out_write_d = 1'b1;
      io_out_d    = mem_q[rptr_q];
      pace_d      = PW'(PACE - 1);
    end else if (pace_q != '0) begin
      pace_d = pace_q - PW'(1);
    end
  end

  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      pace_q      <= '0;
      out_write_q <= 1'b0;
      io_out_q    <= '0;
      overflow_q  <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
      pace_q      <= pace_d;
      out_write_q <= out_write_d;
      io_out_q    <= io_out_d;
      overflow_q  <= overflow_d;
    end
  end

  // Storage needs no reset: the count and pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wptr_q] <= cpu_data;
    end
  end

  assign out_write  = out_write_q;
  assign io_out     = io_out_q;
  assign fifo_count = count_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_io_output_buffer.sv
// Directed bench for io_output_buffer: one PACE=4 instance for latency, fill/overflow and
// reset cases, one PACE=1 instance for back-to-back draining with pointer wrap.

module tb_io_output_buffer;

  logic        clk;
  logic        areset;
  logic        cpu_write, cpu_write1;
  logic [15:0] cpu_data, cpu_data1;
  logic        cpu_ready, cpu_ready1;
  logic        out_write, out_write1;
  logic [15:0] io_out, io_out1;
  logic [3:0]  fifo_count, fifo_count1;
  logic        overflow, overflow1;

  int n_chk  = 0;
  int n_fail = 0;

  io_output_buffer #(.WIDTH(16), .DEPTH(8), .PACE(4)) dut (
    .clk        (clk),
    .areset     (areset),
    .cpu_write  (cpu_write),
    .cpu_data   (cpu_data),
    .cpu_ready  (cpu_ready),
    .out_write  (out_write),
    .io_out     (io_out),
    .fifo_count (fifo_count),
    .overflow   (overflow)
  );

  io_output_buffer #(.WIDTH(16), .DEPTH(8), .PACE(1)) dut1 (
    .clk        (clk),
    .areset     (areset),
    .cpu_write  (cpu_write1),
    .cpu_data   (cpu_data1),
    .cpu_ready  (cpu_ready1),
    .out_write  (out_write1),
    .io_out     (io_out1),
    .fifo_count (fifo_count1),
    .overflow   (overflow1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, then settle 1ns past it before driving or sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    areset     = 1'b0;
    cpu_write  = 1'b0;
    cpu_data   = '0;
    cpu_write1 = 1'b0;
    cpu_data1  = '0;
    #12;
    check("rst_out_write", 32'(out_write), 32'h0);
    check("rst_io_out", 32'(io_out), 32'h0);
    check("rst_count", 32'(fifo_count), 32'h0);
    check("rst_overflow", 32'(overflow), 32'h0);
    check("rst_ready", 32'(cpu_ready), 32'h1);
    areset = 1'b1;
    tick();

    // Single write: pulse between edges k+1 and k+2.
    cpu_write = 1'b1;
    cpu_data  = 16'h0041;
    tick();
    cpu_write = 1'b0;
    check("single_count_k", 32'(fifo_count), 32'h1);
    check("single_nopulse_k", 32'(out_write), 32'h0);
    tick();
    check("single_pulse", 32'(out_write), 32'h1);
    check("single_data", 32'(io_out), 32'h41);
    check("single_count_k1", 32'(fifo_count), 32'h0);
    tick();
    check("single_pulse_end", 32'(out_write), 32'h0);
    check("single_io_hold", 32'(io_out), 32'h41);
    check("single_overflow", 32'(overflow), 32'h0);
    tick();
    tick();
    check("single_quiet", 32'(out_write), 32'h0);

    // Continuous writes 0x30.. at edges 0..13; pops land on edges 1,5,9,...
    // Count reaches 8 after edge 10, so 0x3B..0x3D are dropped; edge 13 is full+pop.
    for (int i = 0; i <= 45; i++) begin
      cpu_write = (i <= 13);
      cpu_data  = 16'(16'h30 + i);
      tick();
      if ((i % 4 == 1) && (i <= 41)) begin
        check($sformatf("burst_pulse_e%0d", i), 32'(out_write), 32'h1);
        check($sformatf("burst_data_e%0d", i), 32'(io_out), 32'(16'h30 + (i - 1) / 4));
      end else begin
        check($sformatf("burst_nopulse_e%0d", i), 32'(out_write), 32'h0);
      end
      if (i == 9) check("burst_ready_e9", 32'(cpu_ready), 32'h1);
      if (i == 10) begin
        check("burst_full_count", 32'(fifo_count), 32'h8);
        check("burst_full_ready", 32'(cpu_ready), 32'h0);
        check("burst_no_ovf_yet", 32'(overflow), 32'h0);
      end
      if (i == 11) check("burst_ovf_set", 32'(overflow), 32'h1);
      if (i == 13) begin
        check("full_pop_count", 32'(fifo_count), 32'h7);
        check("full_pop_ovf", 32'(overflow), 32'h1);
        check("full_pop_ready", 32'(cpu_ready), 32'h1);
      end
    end
    check("burst_drained", 32'(fifo_count), 32'h0);
    check("burst_ovf_sticky", 32'(overflow), 32'h1);

    // Queue 7 words: pops at edges 1 and 5 leave 5 entries, mid-gap after edge 6.
    for (int i = 0; i <= 6; i++) begin
      cpu_write = 1'b1;
      cpu_data  = 16'(16'h70 + i);
      tick();
    end
    cpu_write = 1'b0;
    check("pre_rst_count", 32'(fifo_count), 32'h5);
    check("pre_rst_gap", 32'(out_write), 32'h0);
    #2;
    areset = 1'b0;
    #1;
    check("mid_rst_out_write", 32'(out_write), 32'h0);
    check("mid_rst_io_out", 32'(io_out), 32'h0);
    check("mid_rst_count", 32'(fifo_count), 32'h0);
    check("mid_rst_overflow", 32'(overflow), 32'h0);
    tick();
    #2;
    areset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check($sformatf("post_rst_quiet_%0d", i), 32'(out_write), 32'h0);
    end
    cpu_write = 1'b1;
    cpu_data  = 16'h005A;
    tick();
    cpu_write = 1'b0;
    check("post_rst_count", 32'(fifo_count), 32'h1);
    check("post_rst_nopulse", 32'(out_write), 32'h0);
    tick();
    check("post_rst_pulse", 32'(out_write), 32'h1);
    check("post_rst_data", 32'(io_out), 32'h5A);

    // PACE=1: a write every other edge, each popped on the next edge; pointers wrap twice.
    for (int i = 0; i <= 41; i++) begin
      cpu_write1 = (i % 2 == 0) && (i < 40);
      cpu_data1  = 16'(16'h61 + i / 2);
      tick();
      if ((i % 2 == 1) && (i <= 39)) begin
        check($sformatf("p1_pulse_e%0d", i), 32'(out_write1), 32'h1);
        check($sformatf("p1_data_e%0d", i), 32'(io_out1), 32'(16'h61 + i / 2));
        check($sformatf("p1_count_e%0d", i), 32'(fifo_count1), 32'h0);
      end else begin
        check($sformatf("p1_nopulse_e%0d", i), 32'(out_write1), 32'h0);
        check($sformatf("p1_count_e%0d", i), 32'(fifo_count1), (i < 40) ? 32'h1 : 32'h0);
      end
    end
    check("p1_overflow", 32'(overflow1), 32'h0);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
